// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply at accept; divide stays iterative.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    mb_q, mb_d;
    logic [2:0]      op_q, op_d;
    logic            sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_d;
    logic            busy_d, done_d;

    // Operand decode at accept: signedness, magnitudes and shortcut detection
    logic            a_signed, b_signed, a_neg, b_neg, div0, ovf, accept;
    logic [W-1:0]    a_mag, b_mag;

    always_comb begin
        a_signed = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
        b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg    = a_signed && a[W-1];
        b_neg    = b_signed && b[W-1];
        a_mag    = a_neg ? W'(-a) : a;
        b_mag    = b_neg ? W'(-b) : b;
        div0     = op[2] && (b == '0);
        ovf      = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        accept   = start && !flush && ((state_q == IDLE) || (state_q == DONE));
    end

    // One iteration of each algorithm; the divide trial uses a 33-bit partial remainder
    logic [W:0]      mul_sum, div_trial;
    logic [W+1:0]    div_diff;
    logic [2*W-1:0]  mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, mb_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        div_trial = acc_q[2*W-1:W-1];
        div_diff  = {1'b0, div_trial} - {2'b00, mb_q};
        div_next  = div_diff[W+1] ? {div_trial[W-1:0], acc_q[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end

    // Sign correction and result selection
    logic [2*W-1:0]  prod;
    logic [W-1:0]    quo, rem, fix_res;

    always_comb begin
        prod = (sa_q ^ sb_q) ? (2*W)'(-acc_q) : acc_q;
        quo  = (sa_q ^ sb_q) ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
        rem  = sa_q ? W'(-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
        if (!op_q[2]) begin
            fix_res = (op_q == 3'd0) ? prod[W-1:0] : prod[2*W-1:W];
        end else begin
            fix_res = op_q[1] ? rem : quo;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mb_d     = mb_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        result_d = result;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d  = op;
                    cnt_d = '0;
                    sa_d  = a_neg;
                    sb_d  = b_neg;
                    if (div0 || ovf) begin
                        // Special results preloaded raw; cleared signs bypass correction
                        state_d = FIX;
                        sa_d    = 1'b0;
                        sb_d    = 1'b0;
                        acc_d   = div0 ? {a, 32'hFFFF_FFFF} : {32'h0, 32'h8000_0000};
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!op[2]) begin
                        state_d = FIX;
                        acc_d   = (2*W)'(a_mag) * (2*W)'(b_mag);
`endif
                    end else begin
                        state_d = CALC;
                        if (op[2]) begin
                            acc_d = {{W{1'b0}}, a_mag};
                            mb_d  = b_mag;
                        end else begin
                            acc_d = {{W{1'b0}}, b_mag};
                            mb_d  = a_mag;
                        end
                    end
                end
            end
            CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = result;
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mb_q    <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mb_q    <= mb_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            result  <= result_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed plan cases plus randomized ops vs. an arithmetic model.
module tb_muldiv_seq;
    logic        clk, rst_n, start, flush, busy, done;
    logic [2:0]  op;
    logic [31:0] a, b, result;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        logic [2:0]  op;
    } exp_t;

    exp_t        sb_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    logic [31:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, zx, zy, p;
        logic        ov;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        zx = {32'h0, x};
        zy = {32'h0, y};
        ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * zy; return p[63:32]; end
            3'd3: begin p = zx * zy; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ov ? x : 32'($signed(x) / $signed(y));
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ov ? 32'h0 : 32'($signed(x) % $signed(y));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0)) return 2;
        if (((o == 3'd4) || (o == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 2;
        if (!o[2] && FAST) return 2;
        return 34;
    endfunction

    // Called just after a negedge; returns at the negedge of cycle 1
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input bit push);
        exp_t e;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        if (push) begin
            e.res = exp;
            e.acc = cyc;
            e.lat = latency(o, x, y);
            e.op  = o;
            sb_q.push_back(e);
            last_exp = exp;
        end
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        chk("busy_cycle1", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done want done within 50 cycles");
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_done: got done result=%h want no done", result);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("result_op%0d", e.op), result, e.res);
                chk("done_latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("busy_with_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    logic [2:0]  d_op [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] d_a  [14] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    logic [31:0] d_b  [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] d_r  [14] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9};

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            issue(d_op[i], d_a[i], d_b[i], d_r[i], 1'b1);
            wait_done();
            @(negedge clk);
            chk("idle_after_done", {31'b0, busy}, 32'd0);
        end

        // Back-to-back: second start presented in the done cycle
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_done();
        issue(3'd7, 32'd100, 32'd7, 32'd2, 1'b1);
        wait_done();
        @(negedge clk);

        // Start while busy must be ignored
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = 3'd5;
        a = 32'd50;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Flush in cycle 10: no done, result holds
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("busy_after_flush", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("result_hold_flush", result, last_exp);

        // Reset mid-CALC clears outputs immediately
        issue(3'd4, 32'd1000, 32'd3, 32'h0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("idle_after_rst", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom);
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, model(ro, ra, rb), 1'b1);
            wait_done();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
